// File: rtl/mux.sv
`default_nettype none
// ============================================================================
// Module   : mux
// Brief    : 4:1 single-bit mux with a registered copy of the output and an
//            optional select-change strobe (enabled by macro MUX_SEL_CHG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mux (
    input  logic clk,
    input  logic rst,
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic s0,
    input  logic s1,
    output logic out,
    output logic out_q,
    output logic sel_chg
);

    localparam logic [1:0] c_sel_i0 = 2'b00;
    localparam logic [1:0] c_sel_i1 = 2'b01;
    localparam logic [1:0] c_sel_i2 = 2'b10;
    localparam logic [1:0] c_sel_i3 = 2'b11;

    logic [1:0] w_sel;
    logic       out_d;

    assign w_sel = {s1, s0};

    // Pure combinational path: reset deliberately does not touch it.
    always_comb begin
        out = 1'b0;
        case (w_sel)
            c_sel_i0: out = I0;
            c_sel_i1: out = I1;
            c_sel_i2: out = I2;
            c_sel_i3: out = I3;
            default:  out = 1'b0;
        endcase
    end

    always_comb begin
        out_d = out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef MUX_SEL_CHG_EN
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic       sel_chg_q;
    logic       sel_chg_d;

    // sel_q resets to 00, so the first edge after release flags a nonzero select.
    always_comb begin
        sel_d     = w_sel;
        sel_chg_d = (w_sel != sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= 2'b00;
            sel_chg_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel_chg = sel_chg_q;
`else
    assign sel_chg = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux
// Brief    : Self-checking bench for mux: directed steps plus random traffic
//            compared against a behavioural model of the select/strobe rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux;

    logic clk;
    logic rst;
    logic I0, I1, I2, I3;
    logic s0, s1;
    logic out, out_q, sel_chg;

    int checks = 0;
    int errors = 0;

`ifdef MUX_SEL_CHG_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    // Reference state: last select seen at an edge, expected registered outputs.
    int m_last_sel = 0;
    logic m_out_q  = 1'b0;
    logic m_chg    = 1'b0;

    mux dut (
        .clk     (clk),
        .rst     (rst),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .s0      (s0),
        .s1      (s1),
        .out     (out),
        .out_q   (out_q),
        .sel_chg (sel_chg)
    );

    // Clock starts late so the opening combinational checks see no edge.
    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ins, input int sel, input logic r);
        {I3, I2, I1, I0} = ins;
        s1  = sel[1];
        s0  = sel[0];
        rst = r;
    endtask

    // One clocked step: drive, check the comb path, take an edge, check registers.
    task automatic step(input string tag, input logic [3:0] ins, input int sel, input logic r);
        logic expect_out;
        drive(ins, sel, r);
        #1;
        expect_out = ins[sel];
        check({tag, "_out"}, out, expect_out);
        @(posedge clk);
        if (r) begin
            m_out_q    = 1'b0;
            m_last_sel = 0;
            m_chg      = 1'b0;
        end else begin
            m_chg      = CHG_EN && (sel != m_last_sel);
            m_last_sel = sel;
            m_out_q    = expect_out;
        end
        #1;
        check({tag, "_out_q"}, out_q, m_out_q);
        check({tag, "_sel_chg"}, sel_chg, m_chg);
    endtask

    initial begin
        logic [3:0] rins;
        int         rsel;
        logic       rrst;

        // Combinational checks before any clock edge exists.
        drive(4'b0001, 0, 1'b0);
        #5;
        check("sel00_i0", out, 1'b1);
        drive(4'b0100, 2, 1'b0);
        #1;
        check("sel10_i2", out, 1'b1);
        drive(4'b0101, 2, 1'b0);
        #1;
        check("sel10_i0_toggle", out, 1'b1);
        drive(4'b0010, 1, 1'b0);
        #1;
        check("sel01_i1", out, 1'b1);
        drive(4'b1000, 3, 1'b0);
        #1;
        check("sel11_i3", out, 1'b1);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] v;
            v    = 4'b1111;
            v[s] = 1'b0;
            drive(v, s, 1'b0);
            #1;
            check("sel_zero", out, 1'b0);
        end

        // Reset for two edges with I0=1: out stays live, registers cleared.
        step("rst_a", 4'b0001, 0, 1'b1);
        step("rst_b", 4'b0001, 0, 1'b1);
        step("rel", 4'b0001, 0, 1'b0);

        // 00 -> 11 held for three cycles: single strobe.
        step("hold_a", 4'b1000, 3, 1'b0);
        step("hold_b", 4'b1000, 3, 1'b0);
        step("hold_c", 4'b1000, 3, 1'b0);

        // Select changing every cycle keeps the strobe high.
        step("walk_a", 4'b0110, 0, 1'b0);
        step("walk_b", 4'b0110, 1, 1'b0);
        step("walk_c", 4'b0110, 2, 1'b0);
        step("walk_d", 4'b0110, 0, 1'b0);

        // Mid-operation reset with a new select, then release on nonzero select.
        step("mid_rst", 4'b1111, 3, 1'b1);
        step("rel_nz", 4'b1111, 2, 1'b0);
        step("rel_nz_hold", 4'b1111, 2, 1'b0);
        step("rst_again", 4'b0000, 0, 1'b1);
        step("rel_zero", 4'b0001, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rins = 4'($urandom_range(0, 15));
            rsel = (($urandom_range(0, 3) == 0) ? m_last_sel : int'($urandom_range(0, 3)));
            rrst = ($urandom_range(0, 15) == 0);
            step("rand", rins, rsel, rrst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 I0  input  1  data input, selected when {s1,s0}=2'b00.
REQ-005 I1  input  1  data input, selected when {s1,s0}=2'b01.
REQ-006 I2  input  1  data input, selected when {s1,s0}=2'b10.
REQ-007 I3  input  1  data input, selected when {s1,s0}=2'b11.
REQ-008 s0  input  1  select LSB.
REQ-009 s1  input  1  select MSB.
REQ-010 out  output  1  combinational mux output.
REQ-011 out_q  output  1  registered copy of out.
REQ-012 sel_chg  output  1  one-cycle strobe on select change.

Function
REQ-013 out SHALL equal the input indexed by sel={s1,s0}: 00->I0, 01->I1, 10->I2, 11->I3.
REQ-014 out SHALL be purely combinational: zero latency, independent of clk and rst, and valid during reset.
REQ-015 out SHALL follow any change on the selected input or on s0/s1 within the same delta/settle time, with no glitch-free guarantee.
REQ-016 Changes on non-selected inputs SHALL NOT affect out.
REQ-017 out_q SHALL load out on every rising clk edge when rst=0, giving 1-cycle latency.
REQ-018 The block SHALL hold an internal 2-bit sel_q register that loads {s1,s0} on every rising clk edge when rst=0.
REQ-019 sel_chg SHALL be registered and SHALL be 1 in the cycle after an edge at which {s1,s0} != sel_q; otherwise 0.
REQ-020 A select held constant SHALL produce no further sel_chg pulses; a select that changes every cycle SHALL hold sel_chg high continuously.
REQ-021 Simultaneous change of s0 and s1 SHALL produce a single one-cycle sel_chg pulse.

Reset
REQ-022 When rst=1 at a rising clk edge, out_q SHALL become 0, sel_q SHALL become 2'b00, and sel_chg SHALL become 0.
REQ-023 Reset asserted mid-operation SHALL override the register updates at that edge.
REQ-024 Reset SHALL NOT affect out.
REQ-025 In the first edge after reset release, sel_chg SHALL assert only if {s1,s0} != 2'b00.

Configuration
REQ-026 The macro MUX_SEL_CHG_EN SHALL control the sel_chg feature.
REQ-027 With MUX_SEL_CHG_EN defined, the block SHALL implement sel_q and sel_chg per REQ-018 to REQ-021 and REQ-025.
REQ-028 Without MUX_SEL_CHG_EN, sel_chg SHALL be tied to constant 0, sel_q SHALL be omitted, and the port list SHALL be unchanged.
REQ-029 out and out_q SHALL behave identically with or without the macro.

Verification
REQ-030 sel=00, I0=1, I1=0, I2=0, I3=0 -> out=1 after 5 time units with no clock edge.
REQ-031 sel=10 (s1=1, s0=0), I2=1, others 0 -> out=1; then I0 toggles -> out stays 1.
REQ-032 sel=01 (s1=0, s0=1), I1=1, others 0 -> out=1; sel=11, I3=1, others 0 -> out=1; all four sel with the selected input=0 -> out=0.
REQ-033 rst=1 for 2 edges with I0=1, sel=00 -> out_q=0 and sel_chg=0 while out=1; rst=0, one edge -> out_q=1.
REQ-034 With MUX_SEL_CHG_EN, sel 00->11 held 3 cycles -> sel_chg=1 for exactly one cycle; without the macro -> sel_chg=0 throughout.
